// File: rtl/fft_4_stream_ctrl_pkg.sv
// rtl/fft_4_stream_ctrl_pkg.sv - shared FSM state type and point count for the 4-point FFT stream controller
package fft_4_stream_ctrl_pkg;

    localparam int FFT_POINTS = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fft_4_stream_ctrl_fft_4.sv
// rtl/fft_4_stream_ctrl_fft_4.sv - combinational 4-point DFT, wrapping two's complement, no scaling
// Ports: x0..x3 (re/im) time-domain samples in; y1..y4 (re/im) bins X0..X3 out.
module fft_4 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] x0_re_i,
    input  logic [DATA_WIDTH-1:0] x0_im_i,
    input  logic [DATA_WIDTH-1:0] x1_re_i,
    input  logic [DATA_WIDTH-1:0] x1_im_i,
    input  logic [DATA_WIDTH-1:0] x2_re_i,
    input  logic [DATA_WIDTH-1:0] x2_im_i,
    input  logic [DATA_WIDTH-1:0] x3_re_i,
    input  logic [DATA_WIDTH-1:0] x3_im_i,
    output logic [DATA_WIDTH-1:0] y1_re_o,
    output logic [DATA_WIDTH-1:0] y1_im_o,
    output logic [DATA_WIDTH-1:0] y2_re_o,
    output logic [DATA_WIDTH-1:0] y2_im_o,
    output logic [DATA_WIDTH-1:0] y3_re_o,
    output logic [DATA_WIDTH-1:0] y3_im_o,
    output logic [DATA_WIDTH-1:0] y4_re_o,
    output logic [DATA_WIDTH-1:0] y4_im_o
);

    // X0 = x0 + x1 + x2 + x3
    assign y1_re_o = x0_re_i + x1_re_i + x2_re_i + x3_re_i;
    assign y1_im_o = x0_im_i + x1_im_i + x2_im_i + x3_im_i;
    // X1 = x0 - j*x1 - x2 + j*x3
    assign y2_re_o = x0_re_i + x1_im_i - x2_re_i - x3_im_i;
    assign y2_im_o = x0_im_i - x1_re_i - x2_im_i + x3_re_i;
    // X2 = x0 - x1 + x2 - x3
    assign y3_re_o = x0_re_i - x1_re_i + x2_re_i - x3_re_i;
    assign y3_im_o = x0_im_i - x1_im_i + x2_im_i - x3_im_i;
    // X3 = x0 + j*x1 - x2 - j*x3
    assign y4_re_o = x0_re_i - x1_im_i - x2_re_i + x3_im_i;
    assign y4_im_o = x0_im_i + x1_re_i - x2_im_i - x3_re_i;

endmodule

// File: rtl/fft_4_stream_ctrl.sv
// rtl/fft_4_stream_ctrl.sv - streaming controller: load 4 samples, compute 4-point DFT, drain 4 bins
// Ports: clk/rst_n; input stream in_valid/in_ready/in_re/in_im; output stream out_valid/out_ready/
// out_re/out_im/out_idx/out_last; busy; frame_cnt only when FFT_4_STREAM_CTRL_FRAME_CNT_EN is defined.
module fft_4_stream_ctrl
    import fft_4_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  busy
`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    localparam logic [1:0] LAST_IDX = 2'(FFT_POINTS - 1);

    state_e                         state_q, state_d;
    logic [1:0]                     cnt_q, cnt_d;
    logic [1:0]                     k_q, k_d;
    logic                           out_valid_q, out_valid_d;
    logic [3:0][DATA_WIDTH-1:0]     x_re_q, x_re_d, x_im_q, x_im_d;
    logic [3:0][DATA_WIDTH-1:0]     bin_re_q, bin_re_d, bin_im_q, bin_im_d;
    logic [3:0][DATA_WIDTH-1:0]     y_re, y_im;

    fft_4 #(.DATA_WIDTH(DATA_WIDTH)) u_fft_4 (
        .x0_re_i (x_re_q[0]), .x0_im_i (x_im_q[0]),
        .x1_re_i (x_re_q[1]), .x1_im_i (x_im_q[1]),
        .x2_re_i (x_re_q[2]), .x2_im_i (x_im_q[2]),
        .x3_re_i (x_re_q[3]), .x3_im_i (x_im_q[3]),
        .y1_re_o (y_re[0]),   .y1_im_o (y_im[0]),
        .y2_re_o (y_re[1]),   .y2_im_o (y_im[1]),
        .y3_re_o (y_re[2]),   .y3_im_o (y_im[2]),
        .y4_re_o (y_re[3]),   .y4_im_o (y_im[3])
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        x_re_d      = x_re_q;
        x_im_d      = x_im_q;
        bin_re_d    = bin_re_q;
        bin_im_d    = bin_im_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    x_re_d[cnt_q] = in_re;
                    x_im_d[cnt_q] = in_im;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == LAST_IDX) state_d = CALC;
                end
            end
            CALC: begin
                bin_re_d = y_re;
                bin_im_d = y_im;
                k_d      = 2'd0;
                state_d  = DRAIN;
            end
            DRAIN: begin
                // First DRAIN cycle only raises out_valid; this gives the
                // two-cycle gap between the last accept and the first offer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    if (k_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        k_d         = 2'd0;
                        state_d     = LOAD;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= 2'd0;
            k_q         <= 2'd0;
            out_valid_q <= 1'b0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            bin_re_q    <= '0;
            bin_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            x_re_q      <= x_re_d;
            x_im_q      <= x_im_d;
            bin_re_q    <= bin_re_d;
            bin_im_q    <= bin_im_d;
        end
    end

    // Bins are registered and only change in CALC, so indexing by k keeps
    // the output stable across stalls and reads 0 right after reset.
    assign in_ready  = (state_q == LOAD);
    assign out_valid = out_valid_q;
    assign out_re    = bin_re_q[k_q];
    assign out_im    = bin_im_q[k_q];
    assign out_idx   = k_q;
    assign out_last  = out_valid_q && (k_q == LAST_IDX);
    assign busy      = (state_q != LOAD) || (cnt_q != 2'd0);

`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (out_last && out_ready) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_4_stream_ctrl.sv
// tb/tb_fft_4_stream_ctrl.sv - scoreboard bench for fft_4_stream_ctrl (optional FFT_4_STREAM_CTRL_FRAME_CNT_EN)
module tb_fft_4_stream_ctrl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re, in_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re, out_im;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         busy;
`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    always #5 clk = ~clk;

    fft_4_stream_ctrl #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [1:0]   idx;
        logic         last;
    } bin_t;

    bin_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic stall    = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, $signed(act), act, $signed(exp), exp);
    endtask

    task automatic push_bin(input logic [W-1:0] re, input logic [W-1:0] im, input logic [1:0] idx);
        bin_t b;
        b.re = re; b.im = im; b.idx = idx; b.last = (idx == 2'd3);
        q.push_back(b);
    endtask

    // Offers one sample after `gap` idle cycles; returns 1ns after the accepting edge.
    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input int gap);
        int n;
        repeat (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
        in_valid = 1'b1; in_re = re; in_im = im;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin n_checks++; $display("FAIL send_timeout: in_ready never rose"); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 600) begin @(posedge clk); #1; n++; end
        if (n >= 600) begin n_checks++; $display("FAIL drain_timeout: %0d bins left", q.size()); end
    endtask

    // Sink stall pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: the values seen at the falling edge decide the next rising edge.
    logic         hold = 1'b0;
    logic [W-1:0] h_re, h_im;
    logic [1:0]   h_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_re", out_re, h_re);
                chk("stall_im", out_im, h_im);
                chk("stall_idx", W'(out_idx), W'(h_idx));
            end
            if (out_valid) chk("in_ready_in_drain", W'(in_ready), W'(0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: idx %0d re %0d with no bin expected", out_idx, $signed(out_re));
                end else begin
                    bin_t e;
                    e = q.pop_front();
                    chk("bin_re", out_re, e.re);
                    chk("bin_im", out_im, e.im);
                    chk("bin_idx", W'(out_idx), W'(e.idx));
                    chk("bin_last", W'(out_last), W'(e.last));
                end
                hold = 1'b0;
            end else if (out_valid) begin
                hold = 1'b1; h_re = out_re; h_im = out_im; h_idx = out_idx;
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic push_1234();
        push_bin(64'd10, 64'd0, 2'd0);
        push_bin(-64'sd2, 64'd2, 2'd1);
        push_bin(-64'sd2, 64'd0, 2'd2);
        push_bin(-64'sd2, -64'sd2, 2'd3);
    endtask

    logic [W-1:0] maxp;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        maxp = {1'b0, {(W-1){1'b1}}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_last", W'(out_last), W'(0));
        chk("rst_out_idx", W'(out_idx), W'(0));
        chk("rst_out_re", out_re, W'(0));
        chk("rst_out_im", out_im, W'(0));
        chk("rst_busy", W'(busy), W'(0));
`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
        chk("rst_frame_cnt", W'(frame_cnt), W'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 1..4 back-to-back with latency checks (4th accept = edge t).
        send(64'd1, 64'd0, 0);
        send(64'd2, 64'd0, 0);
        send(64'd3, 64'd0, 0);
        send(64'd4, 64'd0, 0);
        push_1234();
        chk("lat_t0_valid", W'(out_valid), W'(0));
        chk("lat_t0_in_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        chk("lat_t1_valid", W'(out_valid), W'(0));
        chk("lat_t1_in_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        chk("lat_t2_valid", W'(out_valid), W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("lat_t5_in_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        chk("lat_t6_in_ready", W'(in_ready), W'(1));
        wait_done();

        // Same frame with input gaps and random sink stalls.
        stall = 1'b1;
        send(64'd1, 64'd0, 2);
        send(64'd2, 64'd0, 0);
        send(64'd3, 64'd0, 1);
        send(64'd4, 64'd0, 3);
        push_1234();
        wait_done();
        stall = 1'b0;
        @(posedge clk); #1;

        // Reset after two samples; the next frame must start in slot x0.
        send(64'd9, 64'd9, 0);
        send(64'd7, 64'd7, 0);
        chk("partial_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #2;
        chk("async_rst_busy", W'(busy), W'(0));
        chk("async_rst_in_ready", W'(in_ready), W'(1));
        chk("async_rst_out_valid", W'(out_valid), W'(0));
`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
        chk("async_rst_frame_cnt", W'(frame_cnt), W'(0));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(64'd5, 64'd0, 0);
        send(64'd5, 64'd0, 0);
        send(64'd5, 64'd0, 0);
        send(64'd5, 64'd0, 0);
        push_bin(64'd20, 64'd0, 2'd0);
        push_bin(64'd0, 64'd0, 2'd1);
        push_bin(64'd0, 64'd0, 2'd2);
        push_bin(64'd0, 64'd0, 2'd3);
        wait_done();

        // Max positive ×4: X0 wraps to -4.
        send(maxp, 64'd0, 0);
        send(maxp, 64'd0, 1);
        send(maxp, 64'd0, 0);
        send(maxp, 64'd0, 0);
        push_bin(-64'sd4, 64'd0, 2'd0);
        push_bin(64'd0, 64'd0, 2'd1);
        push_bin(64'd0, 64'd0, 2'd2);
        push_bin(64'd0, 64'd0, 2'd3);
        wait_done();

        // in_valid held with junk through CALC/DRAIN must consume nothing.
        send(64'd1, 64'd0, 0);
        send(64'd2, 64'd0, 0);
        send(64'd3, 64'd0, 0);
        send(64'd4, 64'd0, 0);
        push_1234();
        in_valid = 1'b1; in_re = 64'd99; in_im = 64'd99;
        begin
            int n;
            n = 0;
            while (!out_last && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) begin n_checks++; $display("FAIL last_timeout: out_last never seen"); end
        end
        in_valid = 1'b0;
        wait_done();
        chk("ignored_in_busy", W'(busy), W'(0));
`ifdef FFT_4_STREAM_CTRL_FRAME_CNT_EN
        chk("frame_cnt", W'(frame_cnt), W'(3));
`endif
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_4_stream_ctrl.md
FFT_4_STREAM_CTRL -- requirements
Module: fft_4_stream_ctrl

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 64, width of each real or imaginary sample component.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; its ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample offered.
- in_ready  out  1  block accepts the input sample.
- in_re, in_im  in  DATA_WIDTH each  input sample, two's complement.
- out_valid  out  1  output bin offered.
- out_ready  in  1  sink accepts the output bin.
- out_re, out_im  out  DATA_WIDTH each  output bin.
- out_idx  out  2  bin index k.
- out_last  out  1  high with bin 3.
- busy  out  1  state is not LOAD or sample count is nonzero.

Function
REQ-003 A transfer SHALL occur on a rising clk edge where valid and ready are both high; data SHALL be sampled only on a transfer.
REQ-004 FSM states SHALL be LOAD, CALC and DRAIN; reset state SHALL be LOAD.
REQ-005 In LOAD: in_ready=1, out_valid=0; accepted samples SHALL be stored in slots x0..x3 in arrival order by a 2-bit counter.
- The 4th accepted sample SHALL move the state to CALC and wrap the counter to 0.
REQ-006 In CALC, lasting exactly 1 cycle: in_ready=0; the fft_4 results SHALL be registered into bins X0..X3; next state SHALL be DRAIN.
REQ-007 In DRAIN: in_ready=0, out_valid=1; out_re/out_im/out_idx SHALL present bin k, starting at k=0.
- k SHALL advance only on an output transfer.
- out_last SHALL be 1 exactly when k=3.
- The transfer of k=3 SHALL return to LOAD.
REQ-008 Latency: if the 4th input is accepted at edge t, out_valid SHALL be high after edge t+2.
- With out_ready held high, bins SHALL be delivered at edges t+3..t+6.
- First in_ready after a frame SHALL be after edge t+6.
- Throughput: at most one frame per 10 cycles.
REQ-009 Output data SHALL stay stable while out_valid=1 and out_ready=0; in_valid idle gaps SHALL not corrupt partial frames.
REQ-010 Arithmetic SHALL be X[k]=sum x[n]*exp(-j*2*pi*k*n/4), computed in DATA_WIDTH two's complement wrapping, with no scaling or saturation.
REQ-011 in_valid asserted outside LOAD SHALL be ignored; no sample is consumed.

Reset
REQ-012 On rst_n low, reset SHALL be immediate and asynchronous: state=LOAD, both counters=0, in_ready=1, out_valid=0, out_last=0, out_idx=0, out_re=0, out_im=0, busy=0, all sample/bin registers=0.
REQ-013 Reset mid-frame, in any state, SHALL discard partial input and undelivered bins; the first transfer after reset release SHALL be slot x0.

Configuration
REQ-014 Macro FFT_4_STREAM_CTRL_FRAME_CNT_EN, when defined, SHALL add output frame_cnt (16-bit, reset 0).
- frame_cnt SHALL increment on each out_last transfer and wrap from 65535 to 0.
- When the macro is undefined, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-015 A shared package SHALL hold the FSM state enum (LOAD, CALC, DRAIN) and the constant FFT_POINTS=4.
REQ-016 The arithmetic SHALL be one instance of the existing combinational fft_4 sub-module.
- fft_4 is parameterised with DATA_WIDTH.
- Its inputs are the x0..x3 slots; its y1..y4 outputs map to X0..X3.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Inputs 1,2,3,4 (im 0) back-to-back, out_ready=1 -> bins (10,0), (-2,2), (-2,0), (-2,-2); out_last on idx 3; first out_valid 2 cycles after the 4th accept.
- Same frame with in_valid gaps and random out_ready stalls -> identical bins; data held stable during stalls; in_ready=0 throughout CALC/DRAIN.
- rst_n pulsed low after 2 samples, then frame 5,5,5,5 -> bins (20,0), (0,0), (0,0), (0,0); no output before the new frame completes.
- Inputs at max positive value 2^(DATA_WIDTH-1)-1 ×4 -> X0 wraps to -4, other bins (0,0).
- With FFT_4_STREAM_CTRL_FRAME_CNT_EN defined, 3 frames -> frame_cnt=3; without it, the bench compiles with no frame_cnt port.
